// File: rtl/noc_cfg_pkg.sv
// Shared NoC configuration: packet format carried between traffic sources and routers.
// Pure type definitions, no logic and no latency.
// No flow control here; handshakes belong to the modules that move packets.
package noc_cfg_pkg;

  // Coordinates are 4 bits wide, so meshes up to 16x16 are representable.
  typedef struct packed {
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [3:0]  x_source;
    logic [3:0]  y_source;
    logic [7:0]  id;
    logic        ant;
    logic        measure;
    logic [1:0]  vc;
    logic [31:0] timestamp;
    logic [15:0] payload;
  } packet_t;

endpackage

// File: rtl/tg_pkg.sv
// Traffic generator constants, burst FSM encoding and small arithmetic helpers.
// Combinational helpers only, zero latency.
// No flow control.
package tg_pkg;

  // Galois mask for taps 16,14,13,11 in a right-shifting register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_MIX  = 16'h9E37;
  localparam int          CNT_W     = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {BST_IDLE = 1'b0, BST_BURST = 1'b1} burst_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Per-channel seed; an all-zero LFSR would lock up, so zero maps to 1.
  function automatic logic [15:0] chan_seed(input logic [15:0] base, input int unsigned ch);
    logic [15:0] s;
    s = base ^ 16'((ch + 1) * SEED_MIX);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

endpackage

// File: rtl/tg_node_queue.sv
// First-word-fall-through packet queue feeding one router injection port.
// Latency 1: a packet written into an empty queue shows at head on the next cycle.
// Push while full is ignored unless a pop happens in the same cycle; no bypass when empty.
module tg_node_queue
  import noc_cfg_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    push,
  input  packet_t push_dat,
  input  logic    pop,
  output packet_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  packet_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage needs no reset: head is only meaningful while the queue is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping; reset flushes contents silently.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_traffic_gen.sv
// Multi-channel LFSR Bernoulli packet source with per-channel FWFT queues and counters.
// Latency 1 from generation to o_data; counters update on the generating/accepting edge.
// Router stalls via i_en; a full queue drops new packets. TRAFFIC_BURST_EN adds bursts.
module noc_traffic_gen
  import noc_cfg_pkg::*;
  import tg_pkg::*;
#(
  parameter int          N_CH        = 5,
  parameter int          X_NODES     = 4,
  parameter int          Y_NODES     = 4,
  parameter int          X_LOC       = 0,
  parameter int          Y_LOC       = 0,
  parameter int          QUEUE_DEPTH = 8,
  parameter int          ANT_PERIOD  = 64,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          BURST_LEN   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        i_enable,
  input  logic [0:N_CH-1][7:0]        i_rate,
  output packet_t [0:N_CH-1]          o_data,
  output logic [0:N_CH-1]             o_data_val,
  input  logic [0:N_CH-1]             i_en,
  output logic [0:N_CH-1][CNT_W-1:0]  o_gen_count,
  output logic [0:N_CH-1][CNT_W-1:0]  o_inj_count,
  output logic [0:N_CH-1][CNT_W-1:0]  o_drop_count
);

  localparam int ANT_DIV = (ANT_PERIOD == 0) ? 1 : ANT_PERIOD;

  logic [31:0] cycle_cnt;
  logic        ant_now;

  assign ant_now = (ANT_PERIOD != 0) && ((cycle_cnt % 32'(ANT_DIV)) == 32'd0);

  // Free-running timestamp source, wraps at 2^32.
  always_ff @(posedge clk) begin
    if (!reset_n) cycle_cnt <= '0;
    else          cycle_cnt <= cycle_cnt + 32'd1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [15:0] CH_SEED = chan_seed(SEED, c);

    logic [15:0]      lfsr;
    logic             hit;
    logic             gen;
    logic             push_ok;
    logic             pop;
    logic             full;
    logic             empty;
    logic [3:0]       rx;
    logic [3:0]       ry;
    logic [3:0]       dx;
    logic [3:0]       dy;
    packet_t          pkt;
    packet_t          head;
    logic [CNT_W-1:0] gen_cnt;
    logic [CNT_W-1:0] inj_cnt;
    logic [CNT_W-1:0] drop_cnt;

    assign hit = i_enable && ((i_rate[c] == 8'hFF) || (lfsr[7:0] < i_rate[c]));

    // LFSR steps every cycle independent of enable so sequences stay reproducible.
    always_ff @(posedge clk) begin
      if (!reset_n) lfsr <= CH_SEED;
      else          lfsr <= lfsr_next(lfsr);
    end

    // Random destination; channel 0 never targets its own node.
    always_comb begin
      rx = 4'(lfsr[15:8] % 8'(X_NODES));
      ry = 4'(lfsr[11:4] % 8'(Y_NODES));
      if (c == 0 && rx == 4'(X_LOC) && ry == 4'(Y_LOC))
        rx = 4'((5'(rx) + 5'd1) % 5'(X_NODES));
    end

`ifdef TRAFFIC_BURST_EN
    burst_state_t state;
    logic [15:0]  burst_rem;
    logic [3:0]   hold_x;
    logic [3:0]   hold_y;

    assign gen = i_enable && ((state == BST_BURST) || hit);
    assign dx  = (state == BST_BURST) ? hold_x : rx;
    assign dy  = (state == BST_BURST) ? hold_y : ry;

    // Burst sequencer: the hit emits the first packet, BURST emits the remaining ones.
    always_ff @(posedge clk) begin
      if (!reset_n || !i_enable) begin
        state     <= BST_IDLE;
        burst_rem <= '0;
        if (!reset_n) begin
          hold_x <= '0;
          hold_y <= '0;
        end
      end else begin
        case (state)
          BST_IDLE: begin
            if (hit && BURST_LEN > 1) begin
              state     <= BST_BURST;
              burst_rem <= 16'(BURST_LEN - 1);
              hold_x    <= rx;
              hold_y    <= ry;
            end
          end
          default: begin
            if (burst_rem <= 16'd1) begin
              state     <= BST_IDLE;
              burst_rem <= '0;
            end else begin
              burst_rem <= burst_rem - 16'd1;
            end
          end
        endcase
      end
    end
`else
    assign gen = hit;
    assign dx  = rx;
    assign dy  = ry;
`endif

    // Assemble the packet generated this cycle.
    always_comb begin
      pkt           = '0;
      pkt.x_dest    = dx;
      pkt.y_dest    = dy;
      pkt.x_source  = 4'(X_LOC);
      pkt.y_source  = 4'(Y_LOC);
      pkt.id        = gen_cnt[7:0];
      pkt.ant       = ant_now;
      pkt.timestamp = cycle_cnt;
      pkt.measure   = 1'b1;
    end

    assign pop     = !empty && i_en[c];
    assign push_ok = gen && (!full || pop);

    tg_node_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk      (clk),
      .reset_n  (reset_n),
      .push     (push_ok),
      .push_dat (pkt),
      .pop      (pop),
      .head     (head),
      .full     (full),
      .empty    (empty)
    );

    // Saturating statistics; a drop still counts as generated.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        gen_cnt  <= '0;
        inj_cnt  <= '0;
        drop_cnt <= '0;
      end else begin
        if (gen)             gen_cnt  <= sat_inc(gen_cnt);
        if (gen && !push_ok) drop_cnt <= sat_inc(drop_cnt);
        if (pop)             inj_cnt  <= sat_inc(inj_cnt);
      end
    end

    assign o_data[c]       = empty ? '0 : head;
    assign o_data_val[c]   = !empty;
    assign o_gen_count[c]  = gen_cnt;
    assign o_inj_count[c]  = inj_cnt;
    assign o_drop_count[c] = drop_cnt;
  end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Randomised bench for noc_traffic_gen against a queue-based reference model.
// Checks every cycle plus directed end-of-phase expectations.
// Router readiness is randomised to exercise stalls and full-queue drops.
module tb_noc_traffic_gen;
  import noc_cfg_pkg::*;

  localparam int N     = 5;
  localparam int XN    = 4;
  localparam int YN    = 4;
  localparam int XL    = 0;
  localparam int YL    = 0;
  localparam int DEPTH = 8;
  localparam int ANTP  = 64;

  logic                   clk;
  logic                   reset_n;
  logic                   i_enable;
  logic [0:N-1][7:0]      i_rate;
  packet_t [0:N-1]        o_data;
  logic [0:N-1]           o_data_val;
  logic [0:N-1]           i_en;
  logic [0:N-1][31:0]     o_gen_count;
  logic [0:N-1][31:0]     o_inj_count;
  logic [0:N-1][31:0]     o_drop_count;

  int checks   = 0;
  int failures = 0;
  int ants     = 0;
  int selfd    = 0;

  // Reference model state
  logic [15:0]  m_lfsr [N];
  int unsigned  m_cycle;
  packet_t      m_q [N][$];
  logic [31:0]  m_gen [N];
  logic [31:0]  m_inj [N];
  logic [31:0]  m_drop [N];

  noc_traffic_gen #(
    .N_CH(N), .X_NODES(XN), .Y_NODES(YN), .X_LOC(XL), .Y_LOC(YL),
    .QUEUE_DEPTH(DEPTH), .ANT_PERIOD(ANTP), .SEED(16'hACE1), .BURST_LEN(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_enable     (i_enable),
    .i_rate       (i_rate),
    .o_data       (o_data),
    .o_data_val   (o_data_val),
    .i_en         (i_en),
    .o_gen_count  (o_gen_count),
    .o_inj_count  (o_inj_count),
    .o_drop_count (o_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Galois step with taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    int unsigned s;
    for (int c = 0; c < N; c++) begin
      s = (32'hACE1 ^ ((c + 1) * 32'h9E37)) & 32'hFFFF;
      m_lfsr[c] = (s == 0) ? 16'h0001 : 16'(s);
      m_q[c].delete();
      m_gen[c] = 0; m_inj[c] = 0; m_drop[c] = 0;
    end
    m_cycle = 0;
  endtask

  task automatic model_edge();
    logic [15:0] v;
    bit          hit;
    int          x, y;
    packet_t     p;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      v   = m_lfsr[c];
      hit = i_enable && (i_rate[c] == 8'hFF || v[7:0] < i_rate[c]);
      if (m_q[c].size() > 0 && i_en[c]) begin
        void'(m_q[c].pop_front());
        m_inj[c] = sat(m_inj[c]);
      end
      if (hit) begin
        x = int'(v[15:8]) % XN;
        y = int'(v[11:4]) % YN;
        if (c == 0 && x == XL && y == YL) x = (x + 1) % XN;
        p = '0;
        p.x_dest    = 4'(x);
        p.y_dest    = 4'(y);
        p.x_source  = 4'(XL);
        p.y_source  = 4'(YL);
        p.id        = m_gen[c][7:0];
        p.ant       = (m_cycle % ANTP) == 0;
        p.timestamp = m_cycle;
        p.measure   = 1'b1;
        m_gen[c] = sat(m_gen[c]);
        if (m_q[c].size() < DEPTH) m_q[c].push_back(p);
        else                       m_drop[c] = sat(m_drop[c]);
      end
      m_lfsr[c] = lfsr_step(v);
    end
    m_cycle++;
  endtask

  task automatic compare_all();
    packet_t exp_p;
    for (int c = 0; c < N; c++) begin
      exp_p = (m_q[c].size() > 0) ? m_q[c][0] : '0;
      chk($sformatf("val%0d", c),  o_data_val[c], (m_q[c].size() > 0));
      chk($sformatf("data%0d", c), o_data[c], exp_p);
      chk($sformatf("gen%0d", c),  o_gen_count[c], m_gen[c]);
      chk($sformatf("inj%0d", c),  o_inj_count[c], m_inj[c]);
      chk($sformatf("drop%0d", c), o_drop_count[c], m_drop[c]);
    end
  endtask

  // Compare, record accepted ch0 packets, advance model and DUT by one edge.
  task automatic step();
    compare_all();
    if (reset_n && o_data_val[0] && i_en[0]) begin
      if (o_data[0].ant) ants++;
      if (o_data[0].x_dest == 4'(XL) && o_data[0].y_dest == 4'(YL)) selfd++;
    end
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs(input bit full_rate);
    for (int c = 0; c < N; c++) begin
      if (full_rate || $urandom_range(0, 3) == 0) i_rate[c] = 8'hFF;
      else                                        i_rate[c] = 8'($urandom_range(0, 255));
    end
    i_en     = 5'($urandom);
    i_enable = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    i_enable = 1'b0;
    i_rate   = '0;
    i_en     = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();

    // Saturating traffic with a ready router
    reset_n  = 1'b1;
    i_enable = 1'b1;
    for (int c = 0; c < N; c++) i_rate[c] = 8'hFF;
    i_en     = '1;
    for (int k = 0; k < 256; k++) begin
      step();
      if (k == 0) chk("val_after_first_edge", o_data_val, 5'b11111);
      if (k == 99) begin
        for (int c = 0; c < N; c++) begin
          chk($sformatf("gen100_%0d", c), o_gen_count[c], 32'd100);
          chk($sformatf("inj99_%0d", c),  o_inj_count[c], 32'd99);
          chk($sformatf("drop0_%0d", c),  o_drop_count[c], 32'd0);
        end
      end
    end
    chk("ants_ch0", ants, 4);
    chk("self_dest_ch0", selfd, 0);

    // Stalled router: queue fills and further packets drop
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    i_en    = '0;
    repeat (20) step();
    for (int c = 0; c < N; c++) begin
      chk($sformatf("stall_gen%0d", c),  o_gen_count[c], 32'd20);
      chk($sformatf("stall_drop%0d", c), o_drop_count[c], 32'd12);
      chk($sformatf("stall_inj%0d", c),  o_inj_count[c], 32'd0);
      chk($sformatf("stall_val%0d", c),  o_data_val[c], 1'b1);
      chk($sformatf("stall_id%0d", c),   o_data[c].id, 8'd0);
    end

    // Random rates and stalls, channel 2 silent
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      randomize_inputs(1'b0);
      i_rate[2] = 8'h00;
      step();
    end
    chk("ch2_gen",  o_gen_count[2], 32'd0);
    chk("ch2_inj",  o_inj_count[2], 32'd0);
    chk("ch2_drop", o_drop_count[2], 32'd0);
    chk("ch2_val",  o_data_val[2], 1'b0);
    chk("ch0_self_dest_random", selfd, 0);

    // Reset with partially full queues, then replay from seed
    for (int k = 0; k < 50; k++) begin
      randomize_inputs(1'b1);
      i_enable = 1'b1;
      step();
    end
    reset_n = 1'b0;
    step();
    chk("rst_val", o_data_val, 5'b00000);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("rst_gen%0d", c),  o_gen_count[c], 32'd0);
      chk($sformatf("rst_inj%0d", c),  o_inj_count[c], 32'd0);
      chk($sformatf("rst_drop%0d", c), o_drop_count[c], 32'd0);
      chk($sformatf("rst_data%0d", c), o_data[c], 76'd0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      randomize_inputs(1'b0);
      step();
    end
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
